data_sram_resp: RTL
===================

# data_sram_resp

Responder for the CPU core's `data_sram_*` port. It serves single-cycle-issue loads and stores from an on-chip word RAM, and a small memory-mapped register window (LED, switch, timer/compare). Read data returns with the fixed one-cycle latency the MEM stage expects. The block sits outside the core and is instantiated beside it in the SoC top.

## Interface

Parameters:
- `ADDR_W`, 12: RAM word-index width; RAM holds 2^ADDR_W 32-bit words.
- `MMIO_HI`, 16'hBFAF: `addr[31:16]` value that selects the register window.

Ports:
- `clk` input 1: clock; one clock domain.
- `rst` input 1: synchronous, active-high reset.
- `data_sram_en` input 1: access request this cycle.
- `data_sram_wen` input 4: byte-lane write enables; 0 means read.
- `data_sram_addr` input 32: byte address; bits [1:0] are ignored.
- `data_sram_wdata` input 32: store data, lane-aligned.
- `data_sram_rdata` output 32: read data for the access issued in the previous cycle.
- `switch` input 8: asynchronous board switches.
- `led` output 16: LED register.
- `timer_int` output 1: timer/compare match flag, sticky.

## Operation

- Decode:
  - `addr[31:16]==MMIO_HI` selects MMIO.
  - Otherwise the access goes to RAM word `addr[ADDR_W+1:2]`; upper bits are ignored, so the RAM aliases.
- Every access with en=1 is read-first. Next-cycle `data_sram_rdata` is the selected word's value before any same-cycle write.
- Write with en=1 and wen≠0: each lane i with wen[i]=1 takes wdata[8i+7:8i]; the other lanes are unchanged. The same rule applies to RAM and to writable MMIO registers.
- When en=0: no state change from the bus, and `data_sram_rdata` holds its last value.
- MMIO map, offset `addr[15:0]`:
  - 16'hF000 LED: RW, bits [15:0]; bits [31:16] read 0 and ignore writes.
  - 16'hF004 SWITCH: RO. Returns the 2-flop-synchronized `switch`, zero-extended. Writes are ignored.
  - 16'hE000 TIMER: RW. Free-running 32-bit up-counter, +1 every cycle, wraps FFFFFFFF→0.
  - 16'hE004 COMPARE: RW.
  - Any other offset: reads return 0; writes are ignored.
- Timer:
  - A TIMER write replaces the increment that cycle: next TIMER = lane-merge(current TIMER, wdata).
  - A TIMER read returns the pre-increment value of the issue cycle.
- Compare:
  - In any cycle with TIMER==COMPARE and no COMPARE write, `timer_int` sets next cycle.
  - Any COMPARE write clears `timer_int` next cycle; the clear wins over a same-cycle match.
  - Once set, `timer_int` stays 1 until a COMPARE write or reset.
- RAM contents are not initialized by reset. The bench writes before it reads.

## Timing

- Reset (`rst`=1 at a clock edge) sets these values next cycle:
  - `data_sram_rdata`=0, `led`=0, TIMER=0, COMPARE=FFFFFFFF, `timer_int`=0, switch synchronizer=0.
- Reset mid-access: the access issued in the reset cycle is discarded. The RAM write is suppressed, and rdata is 0 next cycle.
- Read latency is exactly 1 cycle; there are no stalls and no ready/valid signals.
- Back-to-back accesses every cycle are fully supported. A read in cycle N+1 of a word written in cycle N returns the new value.
- `switch` to SWITCH-register visibility: 2 cycles of synchronization, then a read issued the following cycle.
- Output updates:
  - `led` updates the cycle after its write.
  - `timer_int` is registered: it asserts 1 cycle after the match cycle.

## Test plan

- **Full-word write/read:** write 32'hDEADBEEF to 0x0000_0010 (wen=F), then read the same address -> rdata=DEADBEEF one cycle after the read issue. A read of 0x0000_4010 with ADDR_W=12 (alias) also returns DEADBEEF.
- **Byte lanes and read-first:** word initially 11223344; write wen=4'b0101, wdata=AABBCCDD, then read -> 11BB33DD. A read issued in the write cycle itself returns 11223344.
- **LED and switch:**
  - Write 0xBFAFF000 with wdata=0001ABCD -> `led`=ABCD next cycle; a read returns 0000ABCD.
  - Drive `switch`=8'h5A, wait 3 cycles, read 0xBFAFF004 -> 0000005A.
- **Timer and compare:**
  - Write TIMER=FFFFFFFE and COMPARE=00000001 -> TIMER reads 0 at wrap, and `timer_int`=1 one cycle after TIMER==1.
  - It stays high until a COMPARE write, which drives it to 0 next cycle even if TIMER==COMPARE that cycle.
- **Reset mid-operation:** assert `rst` during a write to LED with TIMER running -> next cycle `led`=0, TIMER=0, COMPARE=FFFFFFFF, `timer_int`=0, rdata=0.
- **Unmapped and idle:**
  - Read 0xBFAF1234 -> 0; a write there changes nothing.
  - With en=0 for 5 cycles, rdata holds its last value.

Source files
------------

// File: rtl/data_sram_resp.sv
// Data-side memory responder: word RAM plus a small register window (LED, switch, timer/compare).
// All accesses are read-first with a fixed one-cycle read latency.
module data_sram_resp #(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_int
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [15:0] OFF_LED  = 16'hF000;
  localparam logic [15:0] OFF_SW   = 16'hF004;
  localparam logic [15:0] OFF_TMR  = 16'hE000;
  localparam logic [15:0] OFF_CMP  = 16'hE004;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       timer_q;
  logic [31:0]       compare_q;
  logic [7:0]        sw_s1_q;
  logic [7:0]        sw_s2_q;

  logic              is_mmio_c;
  logic [ADDR_W-1:0] idx_c;
  logic [15:0]       off_c;
  logic              wr_c;
  logic              ram_wr_c;
  logic              led_wr_c;
  logic              tmr_wr_c;
  logic              cmp_wr_c;
  logic [31:0]       mmio_rd_c;
  logic [31:0]       led_merge_c;
  logic              unused_c;

  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  // Address decode and write strobes; nothing is written in a reset cycle.
  always_comb begin
    is_mmio_c   = (data_sram_addr[31:16] == MMIO_HI);
    idx_c       = data_sram_addr[ADDR_W+1:2];
    off_c       = data_sram_addr[15:0];
    wr_c        = data_sram_en && (data_sram_wen != 4'b0000) && !rst;
    ram_wr_c    = wr_c && !is_mmio_c;
    led_wr_c    = wr_c && is_mmio_c && (off_c == OFF_LED);
    tmr_wr_c    = wr_c && is_mmio_c && (off_c == OFF_TMR);
    cmp_wr_c    = wr_c && is_mmio_c && (off_c == OFF_CMP);
    led_merge_c = lane_merge({16'h0000, led}, data_sram_wdata, data_sram_wen);
    unused_c    = ^{data_sram_addr[1:0], led_merge_c[31:16]};
  end

  always_comb begin
    mmio_rd_c = 32'h0000_0000;
    case (off_c)
      OFF_LED: mmio_rd_c = {16'h0000, led};
      OFF_SW:  mmio_rd_c = {24'h00_0000, sw_s2_q};
      OFF_TMR: mmio_rd_c = timer_q;
      OFF_CMP: mmio_rd_c = compare_q;
      default: mmio_rd_c = 32'h0000_0000;
    endcase
  end

  // RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_wr_c) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[idx_c][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sram_rdata <= 32'h0000_0000;
    end else if (data_sram_en) begin
      data_sram_rdata <= is_mmio_c ? mmio_rd_c : mem[idx_c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= 16'h0000;
      timer_q   <= 32'h0000_0000;
      compare_q <= 32'hFFFF_FFFF;
      timer_int <= 1'b0;
      sw_s1_q   <= 8'h00;
      sw_s2_q   <= 8'h00;
    end else begin
      sw_s1_q <= switch;
      sw_s2_q <= sw_s1_q;
      if (led_wr_c) led <= led_merge_c[15:0];
      timer_q <= tmr_wr_c ? lane_merge(timer_q, data_sram_wdata, data_sram_wen)
                          : timer_q + 32'd1;
      if (cmp_wr_c) compare_q <= lane_merge(compare_q, data_sram_wdata, data_sram_wen);
      // A compare write clears the flag even when a match happens that same cycle.
      if (cmp_wr_c) timer_int <= 1'b0;
      else if (timer_q == compare_q) timer_int <= 1'b1;
    end
  end

endmodule
